div_unit: RTL and testbench

- Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
- Responder side of the hazard unit's divide handshake: it consumes div_start and returns div_ready.
- The hazard unit holds div_start high, stalling IF/ID/EX/MEM, until div_ready pulses. The pipeline then advances and the HI/LO write uses {div_hi, div_lo}.

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared state encoding and control codes for the iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  localparam logic DIV_CONTROL  = 1'b1;
  localparam logic DIVU_CONTROL = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU divider; result pulse DATA_W+1 cycles after accept (2 on divide by zero).
// No backpressure: div_start dropping or div_annul aborts BUSY/ZERO, and div_lo/div_hi hold until the next DONE.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic              div_annul,
  input  logic [DATA_W-1:0] div_a,
  input  logic [DATA_W-1:0] div_b,
  output logic              div_ready,
  output logic [DATA_W-1:0] div_lo,
  output logic [DATA_W-1:0] div_hi
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x, input logic n);
    return n ? (~x + ONE) : x;
  endfunction

  div_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic                ready_q, ready_d;

  logic                sgn_in;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     rem_sh;
  logic                rem_ge;
  logic [DATA_W-1:0]   rem_nx, quo_nx;
  logic                abort;

  assign sgn_in = (div_signed == DIV_CONTROL);
  assign a_mag  = neg_if(div_a, sgn_in & div_a[DATA_W-1]);
  assign b_mag  = neg_if(div_b, sgn_in & div_b[DATA_W-1]);
  assign abort  = div_annul | ~div_start;

  // The shifted partial remainder can need DATA_W+1 bits when the divisor has its MSB set.
  assign rem_sh = work_q[2*DATA_W-1:DATA_W-1];
  assign rem_ge = (rem_sh >= {1'b0, divisor_q});
  assign rem_nx = rem_ge ? (rem_sh[DATA_W-1:0] - divisor_q) : rem_sh[DATA_W-1:0];
  assign quo_nx = {work_q[DATA_W-2:0], rem_ge};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    ready_d   = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (div_start && !div_annul) begin
          work_d    = {{DATA_W{1'b0}}, a_mag};
          divisor_d = b_mag;
          q_neg_d   = sgn_in & (div_a[DATA_W-1] ^ div_b[DATA_W-1]);
          r_neg_d   = sgn_in & div_a[DATA_W-1];
          cnt_d     = '0;
          state_d   = (b_mag == '0) ? DIV_ZERO : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (abort) begin
          state_d = DIV_IDLE;
        end else begin
          work_d = {rem_nx, quo_nx};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = DIV_DONE;
            ready_d = 1'b1;
            lo_d    = neg_if(quo_nx, q_neg_q);
            hi_d    = neg_if(rem_nx, r_neg_q);
          end
        end
      end
      DIV_ZERO: begin
        if (abort) begin
          state_d = DIV_IDLE;
        end else begin
          state_d = DIV_DONE;
          ready_d = 1'b1;
          lo_d    = neg_if({DATA_W{1'b1}}, q_neg_q);
          hi_d    = neg_if(work_q[DATA_W-1:0], r_neg_q);
        end
      end
      DIV_DONE: begin
        // Result was registered on entry; aborts here are left to the pipeline flush.
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      ready_q   <= ready_d;
    end
  end

  assign div_ready = ready_q;
  assign div_lo    = lo_q;
  assign div_hi    = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: table of divides plus abort/reset sequences.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        resetn;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_ready;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_annul  (div_annul),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_ready  (div_ready),
    .div_lo     (div_lo),
    .div_hi     (div_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input int idx);
    int lat;
    lat        = 0;
    div_a      = vecs[idx].a;
    div_b      = vecs[idx].b;
    div_signed = vecs[idx].sgn;
    div_start  = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (div_ready) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(vecs[idx].lat));
    chk($sformatf("v%0d lo", idx), div_lo, vecs[idx].lo);
    chk($sformatf("v%0d hi", idx), div_hi, vecs[idx].hi);
    // start is still high across the DONE edge; it must not be re-accepted
    tick();
    chk($sformatf("v%0d ready after pulse", idx), {31'b0, div_ready}, 32'h0);
    div_start = 1'b0;
    tick();
    chk($sformatf("v%0d ready idle", idx), {31'b0, div_ready}, 32'h0);
    chk($sformatf("v%0d lo held", idx), div_lo, vecs[idx].lo);
  endtask

  initial begin
    int pulses;
    logic [31:0] lo_prev, hi_prev;

    vecs[0] = '{32'd100,      32'd7,          DIVU_CONTROL, 32'h0000000E, 32'h00000002, 33};
    vecs[1] = '{32'hFFFFFFF9, 32'h00000002,   DIV_CONTROL,  32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[2] = '{32'h00000007, 32'hFFFFFFFE,   DIV_CONTROL,  32'hFFFFFFFD, 32'h00000001, 33};
    vecs[3] = '{32'h12345678, 32'h00000000,   DIVU_CONTROL, 32'hFFFFFFFF, 32'h12345678, 2};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF,   DIV_CONTROL,  32'h80000000, 32'h00000000, 33};
    vecs[5] = '{32'd9,        32'd2,          DIVU_CONTROL, 32'h00000004, 32'h00000001, 33};
    vecs[6] = '{32'hFFFFFFFF, 32'h00000010,   DIVU_CONTROL, 32'h0FFFFFFF, 32'h0000000F, 33};
    vecs[7] = '{32'hFFFFFFFF, 32'h80000000,   DIVU_CONTROL, 32'h00000001, 32'h7FFFFFFF, 33};
    vecs[8] = '{32'hFFFFFF9C, 32'hFFFFFFF9,   DIV_CONTROL,  32'h0000000E, 32'hFFFFFFFE, 33};
    vecs[9] = '{32'd5,        32'd9,          DIVU_CONTROL, 32'h00000000, 32'h00000005, 33};

    resetn     = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    div_a      = '0;
    div_b      = '0;
    repeat (3) tick();
    chk("reset ready", {31'b0, div_ready}, 32'h0);
    chk("reset lo", div_lo, 32'h0);
    chk("reset hi", div_hi, 32'h0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      run_div(i);
    end

    // annul pulse in cycle 10 of a divide: no result, outputs untouched
    lo_prev    = div_lo;
    hi_prev    = div_hi;
    pulses     = 0;
    div_a      = 32'd100;
    div_b      = 32'd7;
    div_signed = DIVU_CONTROL;
    div_start  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (div_ready) pulses++;
    end
    div_annul = 1'b1;
    tick();
    div_annul = 1'b0;
    div_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (div_ready) pulses++;
      tick();
    end
    chk("annul ready pulses", 32'(pulses), 32'h0);
    chk("annul lo kept", div_lo, lo_prev);
    chk("annul hi kept", div_hi, hi_prev);

    // start dropped mid-BUSY also aborts
    pulses    = 0;
    div_a     = 32'hFFFFFFFF;
    div_b     = 32'd3;
    div_start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (div_ready) pulses++;
    end
    div_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (div_ready) pulses++;
    end
    chk("start drop ready pulses", 32'(pulses), 32'h0);
    chk("start drop lo kept", div_lo, lo_prev);

    // divider still healthy after aborts
    run_div(0);

    // asynchronous reset in cycle 20 of a divide clears outputs immediately
    div_a      = 32'hFFFFFFF9;
    div_b      = 32'h00000002;
    div_signed = DIV_CONTROL;
    div_start  = 1'b1;
    repeat (20) tick();
    chk("pre-reset lo", div_lo, vecs[0].lo);
    #1;
    resetn = 1'b0;
    #1;
    chk("async reset ready", {31'b0, div_ready}, 32'h0);
    chk("async reset lo", div_lo, 32'h0);
    chk("async reset hi", div_hi, 32'h0);
    div_start = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    run_div(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
